// File: rtl/music_sheet_pkg.sv
// Shared types and defaults for the multi-track music sheet recorder.
package music_sheet_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } state_t;

  localparam int DEF_ADDR_WIDTH  = 5;
  localparam int DEF_NOTE_WIDTH  = 4;
  localparam int DEF_TRACKS      = 2;
  localparam int DEF_BEAT_CYCLES = 4;

  // A single track still needs a one-bit select so the port never collapses to zero width.
  function automatic int track_w(input int tracks);
    return (tracks <= 1) ? 1 : $clog2(tracks);
  endfunction

endpackage

// File: rtl/note_memory.sv
// Simple dual-port note RAM: synchronous write, registered read, addressed as {track, addr}.
module note_memory
  import music_sheet_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_WIDTH + 1,
  parameter int DATA_W = DEF_NOTE_WIDTH,
  parameter int WORDS  = DEF_TRACKS << DEF_ADDR_WIDTH
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [WORDS];

  // Contents are intentionally not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/music_sheet_recorder.sv
// Multi-track note recorder: records Enter-strobed notes while Start is held and
// plays a selected track back at a fixed beat rate, optionally looping.
module music_sheet_recorder
  import music_sheet_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NOTE_WIDTH  = DEF_NOTE_WIDTH,
  parameter int TRACKS      = DEF_TRACKS,
  parameter int BEAT_CYCLES = DEF_BEAT_CYCLES,
  localparam int TRACK_W    = track_w(TRACKS)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Enter,
  input  logic                  Play,
  input  logic                  Loop,
  input  logic [TRACK_W-1:0]    Track,
  input  logic [NOTE_WIDTH-1:0] NoteIn,
  output logic [ADDR_WIDTH-1:0] CurrentAddress,
  output logic                  Recording,
  output logic                  Playing,
  output logic                  Full,
  output logic [NOTE_WIDTH-1:0] NoteOut,
  output logic                  NoteValid
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int MEM_AW = TRACK_W + ADDR_WIDTH;
  localparam int WORDS  = TRACKS * DEPTH;
  localparam int BEAT_W = (BEAT_CYCLES <= 2) ? 1 : $clog2(BEAT_CYCLES);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  state_t                 state;
  logic                   start_q;
  logic                   enter_q;
  logic                   play_q;
  logic [TRACK_W-1:0]     trk;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       lengths [TRACKS];
  logic [BEAT_W-1:0]      beat;
  logic                   full;
  logic                   read_pending;
  logic [NOTE_WIDTH-1:0]  note_out;
  logic                   note_valid;
  logic [NOTE_WIDTH-1:0]  rd_data;

  logic                   start_rise;
  logic                   start_fall;
  logic                   enter_rise;
  logic                   play_rise;
  logic                   play_fall;
  logic [CNT_W-1:0]       sel_len;
  logic [CNT_W-1:0]       last_addr;
  logic                   at_last;
  logic                   wr_en;
  logic                   rd_en;

  assign start_rise = Start & ~start_q;
  assign start_fall = ~Start & start_q;
  assign enter_rise = Enter & ~enter_q;
  assign play_rise  = Play & ~play_q;
  assign play_fall  = ~Play & play_q;

  assign sel_len   = lengths[Track];
  assign last_addr = lengths[trk] - 1'b1;
  assign at_last   = ({1'b0, addr} == last_addr);

  // count never exceeds DEPTH, so its top bit alone marks a full track.
  assign wr_en = (state == RECORD) && !start_fall && enter_rise && !count[ADDR_WIDTH];
  assign rd_en = (state == PLAY) && !play_fall && (beat == BEAT_LAST);

  note_memory #(
    .ADDR_W (MEM_AW),
    .DATA_W (NOTE_WIDTH),
    .WORDS  (WORDS)
  ) u_mem (
    .clk     (Clock),
    .wr_en   (wr_en),
    .wr_addr ({trk, addr}),
    .wr_data (NoteIn),
    .rd_en   (rd_en),
    .rd_addr ({trk, addr}),
    .rd_data (rd_data)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      enter_q      <= 1'b0;
      play_q       <= 1'b0;
      trk          <= '0;
      addr         <= '0;
      count        <= '0;
      beat         <= '0;
      full         <= 1'b0;
      read_pending <= 1'b0;
      note_out     <= '0;
      note_valid   <= 1'b0;
      for (int i = 0; i < TRACKS; i++) lengths[i] <= '0;
    end else begin
      start_q <= Start;
      enter_q <= Enter;
      play_q  <= Play;

      // A read issued last cycle always delivers, even if the session just ended.
      read_pending <= rd_en;
      note_valid   <= read_pending;
      if (read_pending) note_out <= rd_data;

      case (state)
        IDLE: begin
          if (start_rise) begin
            state <= RECORD;
            trk   <= Track;
            addr  <= '0;
            count <= '0;
            full  <= 1'b0;
          end else if (play_rise && !Start && (sel_len != '0)) begin
            state <= PLAY;
            trk   <= Track;
            addr  <= '0;
            beat  <= '0;
          end
        end

        RECORD: begin
          if (start_fall) begin
            state        <= IDLE;
            lengths[trk] <= count;
          end else if (wr_en) begin
            count <= count + 1'b1;
            addr  <= addr + 1'b1;
            full  <= ((count + 1'b1) == CNT_FULL);
          end
        end

        PLAY: begin
          if (play_fall) begin
            state <= IDLE;
          end else if (rd_en) begin
            beat <= '0;
            if (at_last) begin
              if (Loop) addr  <= '0;
              else      state <= IDLE;
            end else begin
              addr <= addr + 1'b1;
            end
          end else begin
            beat <= beat + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign CurrentAddress = addr;
  assign Recording      = (state == RECORD);
  assign Playing        = (state == PLAY);
  assign Full           = full;
  assign NoteOut        = note_out;
  assign NoteValid      = note_valid;

endmodule

// File: tb/tb_music_sheet_recorder.sv
// Directed-plus-random bench for music_sheet_recorder with a note-list reference model.
module tb_music_sheet_recorder;

  localparam int AW    = 5;
  localparam int NW    = 4;
  localparam int TR    = 2;
  localparam int BC    = 4;
  localparam int DEPTH = 1 << AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          Start;
  logic          Enter;
  logic          Play;
  logic          Loop;
  logic [0:0]    Track;
  logic [NW-1:0] NoteIn;
  logic [AW-1:0] CurrentAddress;
  logic          Recording;
  logic          Playing;
  logic          Full;
  logic [NW-1:0] NoteOut;
  logic          NoteValid;

  int total = 0;
  int bad   = 0;

  logic [NW-1:0] model_mem [TR][DEPTH];
  int            model_len [TR];
  logic [NW-1:0] pending_notes [$];

  music_sheet_recorder #(
    .ADDR_WIDTH  (AW),
    .NOTE_WIDTH  (NW),
    .TRACKS      (TR),
    .BEAT_CYCLES (BC)
  ) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Start          (Start),
    .Enter          (Enter),
    .Play           (Play),
    .Loop           (Loop),
    .Track          (Track),
    .NoteIn         (NoteIn),
    .CurrentAddress (CurrentAddress),
    .Recording      (Recording),
    .Playing        (Playing),
    .Full           (Full),
    .NoteOut        (NoteOut),
    .NoteValid      (NoteValid)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic e, input logic p, input logic l,
                               input int trk, input logic [NW-1:0] note);
    Start  = s;
    Enter  = e;
    Play   = p;
    Loop   = l;
    Track  = 1'(trk);
    NoteIn = note;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_addr"}, CurrentAddress, 0);
    checkOutput({tag, "_rec"}, Recording, 0);
    checkOutput({tag, "_play"}, Playing, 0);
    checkOutput({tag, "_full"}, Full, 0);
    checkOutput({tag, "_note"}, NoteOut, 0);
    checkOutput({tag, "_valid"}, NoteValid, 0);
  endtask

  // Records every queued note; with enter_on_fall the last one is strobed together with Start fall.
  task automatic recordTrack(input int t, input bit enter_on_fall);
    int cnt;
    logic [NW-1:0] n;
    cnt = 0;
    applyStimulus(1, 0, 0, 0, t, 0);
    checkOutput("rec_start", Recording, 1);
    checkOutput("rec_addr0", CurrentAddress, 0);
    checkOutput("rec_full0", Full, 0);
    while (pending_notes.size() > (enter_on_fall ? 1 : 0)) begin
      n = pending_notes.pop_front();
      applyStimulus(1, 1, 0, 0, int'($urandom_range(1)), n);
      if (cnt < DEPTH) begin
        model_mem[t][cnt] = n;
        cnt++;
      end
      checkOutput("rec_addr", CurrentAddress, cnt % DEPTH);
      checkOutput("rec_full", Full, cnt == DEPTH);
      applyStimulus(1, 0, 0, 0, int'($urandom_range(1)), 0);
      checkOutput("rec_hold", CurrentAddress, cnt % DEPTH);
    end
    n = enter_on_fall ? pending_notes.pop_front() : '0;
    applyStimulus(0, enter_on_fall, 0, 0, int'($urandom_range(1)), n);
    checkOutput("rec_stop", Recording, 0);
    checkOutput("rec_stop_addr", CurrentAddress, cnt % DEPTH);
    model_len[t] = cnt;
    applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  // Reads land every BC cycles after entry; each delivers one cycle later. Play drops at drop_c.
  task automatic playCheck(input int t, input logic lp, input int drop_c);
    int len;
    len = model_len[t];
    applyStimulus(0, 0, 1, lp, t, 0);
    checkOutput("play_entry", Playing, len != 0);
    if (len == 0) begin
      for (int c = 0; c < BC + 2; c++) begin
        applyStimulus(0, 0, 1, lp, int'($urandom_range(1)), 0);
        checkOutput("play_ignored", Playing, 0);
        checkOutput("play_ignored_valid", NoteValid, 0);
      end
    end else begin
      for (int c = 1; c <= drop_c; c++) begin
        int r;
        bit read_prev;
        r = c - 1;
        read_prev = (r >= BC) && (r % BC == 0) && (lp || (r / BC) <= len);
        applyStimulus(0, 0, c != drop_c, lp, int'($urandom_range(1)), 0);
        checkOutput("playing", Playing, (c < drop_c) && (lp || c < len * BC));
        checkOutput("note_valid", NoteValid, read_prev);
        if (read_prev) checkOutput("note_out", NoteOut, model_mem[t][((r / BC) - 1) % len]);
      end
    end
    for (int c = 0; c < 2 * BC; c++) begin
      applyStimulus(0, 0, 0, lp, 0, 0);
      checkOutput("idle_valid", NoteValid, 0);
      checkOutput("idle_playing", Playing, 0);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    Enter  = 1'b0;
    Play   = 1'b0;
    Loop   = 1'b0;
    Track  = 1'b0;
    NoteIn = '0;
    for (int i = 0; i < TR; i++) model_len[i] = 0;

    repeat (6) tick();
    checkAllZero("in_reset");
    Reset = 1'b0;
    tick();
    checkAllZero("post_reset");

    $display("[TB] record 3,7,9 on track 0");
    pending_notes.push_back(4'd3);
    pending_notes.push_back(4'd7);
    pending_notes.push_back(4'd9);
    recordTrack(0, 0);

    $display("[TB] play track 0 once, then looping with a mid-beat abort");
    playCheck(0, 1'b0, 3 * BC + 4);
    playCheck(0, 1'b1, 5 * BC + 3);

    $display("[TB] fill track 1 with 33 random notes");
    for (int i = 0; i < DEPTH + 1; i++) pending_notes.push_back(NW'($urandom));
    recordTrack(1, 0);
    playCheck(1, 1'b0, DEPTH * BC + 3);

    $display("[TB] re-record track 0, last Enter coincides with Start fall");
    for (int i = 0; i < 5; i++) pending_notes.push_back(NW'($urandom));
    recordTrack(0, 1);
    playCheck(0, 1'b1, 8 * BC + 1);

    $display("[TB] Start and Play rise together");
    applyStimulus(1, 0, 1, 0, 1, 0);
    checkOutput("both_rec", Recording, 1);
    checkOutput("both_play", Playing, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("both_stop", Recording, 0);
    model_len[1] = 0;
    playCheck(1, 1'b0, 1);

    $display("[TB] reset during playback");
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkOutput("rst_play_entry", Playing, 1);
    repeat (BC + 2) applyStimulus(0, 0, 1, 1, 0, 0);
    Reset = 1'b1;
    #1;
    checkAllZero("async_reset");
    for (int i = 0; i < TR; i++) model_len[i] = 0;
    tick();
    Reset = 1'b0;
    applyStimulus(0, 0, 0, 1, 0, 0);
    playCheck(0, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/music_sheet_recorder.md
# music_sheet_recorder

Multi-track, parametrised successor to the single-track music sheet writer in the Pong audio path. It records note codes entered with a debounced Enter pushbutton into per-track note memory while Start is held. It plays a selected track back at a fixed beat rate, with optional looping, to the tone generator. Recorded length is kept per track so playback stops, or wraps, exactly at the last entered note.

## Interface
- ADDR_WIDTH, 5: note address width; per-track depth DEPTH = 2^ADDR_WIDTH
- NOTE_WIDTH, 4: note code width
- TRACKS, 2: number of tracks (>=1); TRACK_W = max(1, clog2(TRACKS))
- BEAT_CYCLES, 4: clock cycles per playback beat (>=2)
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; returns the block to IDLE
- Start  in  1  level; rising edge begins recording, falling edge ends it
- Enter  in  1  level, already debounced; each rising edge stores one note
- Play  in  1  level; rising edge begins playback, falling edge aborts it
- Loop  in  1  level; sampled at the end of a track: 1 = wrap, 0 = stop
- Track  in  TRACK_W  track select; latched on session entry
- NoteIn  in  NOTE_WIDTH  note code written on an Enter edge
- CurrentAddress  out  ADDR_WIDTH  next write / next read address
- Recording  out  1  FSM in RECORD
- Playing  out  1  FSM in PLAY
- Full  out  1  recording track holds DEPTH notes
- NoteOut  out  NOTE_WIDTH  registered playback note
- NoteValid  out  1  one-cycle pulse; NoteOut is new this cycle

## Operation
- Edge detection uses registered copies of Start, Enter and Play, reset to 0. rise = x & ~x_q, fall = ~x & x_q.
- State IDLE:
  - Start rise -> RECORD. Latch Track, address = 0, count = 0, clear Full.
  - Otherwise Play rise, with Start low and length[Track] != 0 -> PLAY. Latch Track, address = 0, beat = 0.
  - If both rise in the same cycle, RECORD wins.
  - Play rise on a track with length 0 is ignored.
- State RECORD:
  - Start fall -> IDLE, length[trk] = count. An Enter rise in that same cycle is dropped.
  - Otherwise, on an Enter rise with count < DEPTH: write NoteIn at {trk, address}, count++, address++ (wraps to 0 at DEPTH).
  - Full = (count == DEPTH). Enter rises while Full are ignored.
  - count is ADDR_WIDTH+1 bits.
- State PLAY:
  - Play fall -> IDLE immediately. Any pending NoteValid still fires.
  - Otherwise beat increments each cycle. When beat == BEAT_CYCLES-1, beat = 0 and a read is issued at address.
  - The next cycle, NoteOut = mem data and NoteValid = 1.
  - If address == length[trk]-1 at the read: with Loop = 1, address = 0; with Loop = 0, go to IDLE (the final NoteValid still fires). Otherwise address++.
- Track input changes during RECORD or PLAY are ignored.
- Re-recording a track overwrites it from address 0 and replaces its length.

## Timing
- Reset values: CurrentAddress 0, Recording 0, Playing 0, Full 0, NoteOut 0, NoteValid 0, all lengths 0, FSM IDLE. Memory contents are not reset.
- Reset mid-session aborts the session and clears all lengths.
- Enter sampled high at edge k (low at k-1): the write occurs at edge k, and CurrentAddress shows +1 after edge k.
- Start rise sampled at edge k: Recording = 1 after edge k.
- Playback: PLAY entered at edge e0, first read at edge e0+BEAT_CYCLES, NoteValid high after edge e0+BEAT_CYCLES+1. Subsequent NoteValid pulses are BEAT_CYCLES apart.
- Memory read latency is 1 cycle (synchronous read).
- Write and read never coincide, because RECORD and PLAY are exclusive.

## Structure
- Package music_sheet_pkg:
  - state enum {IDLE, RECORD, PLAY}
  - default parameter constants
  - TRACK_W helper function
- Sub-module note_memory: simple dual-port RAM, depth TRACKS*DEPTH, width NOTE_WIDTH. Synchronous write, registered read, address {track, addr}.
- Top contains the edge detectors, FSM, per-track length registers, beat counter and output registers.

## Test plan
- Reset 1 for 6 cycles, Start rise, Enter pulses with NoteIn 3, 7, 9, then Start fall -> CurrentAddress 0,1,2,3; Recording falls the cycle after Start fall; length[0] = 3.
- Play track 0, Loop = 0, BEAT_CYCLES = 4 -> NoteValid pulses with NoteOut 3, 7, 9 four cycles apart, first pulse 5 cycles after entry; Playing falls at the third read.
- Same track with Loop = 1 -> sequence 3, 7, 9, 3, 7 continuing; drop Play mid-beat -> IDLE next cycle, no further NoteValid.
- Record 33 Enter pulses on track 1 with ADDR_WIDTH = 5 -> Full = 1 after the 32nd; the 33rd is ignored; length[1] = 32; CurrentAddress wrapped to 0.
- Enter rise in the same cycle as Start fall -> note not written, count unchanged; Start and Play rising together -> RECORD.
- Assert Reset during PLAY -> all outputs 0 immediately; a later Play on track 0 is ignored (length 0).
